// File: rtl/exec_pkg.sv
// Shared definitions for the N-lane execute stage: ALU op codes, B-operand
// select codes and the op legality check.
package exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_NOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;
  localparam logic [3:0] ALU_MUL  = 4'hC;

  localparam logic [1:0] SRC_REG   = 2'd0;
  localparam logic [1:0] SRC_IMM   = 2'd1;
  localparam logic [1:0] SRC_SHAMT = 2'd2;

  // MUL is only legal when the multi-cycle multiplier is built in.
  function automatic logic op_legal(input logic [3:0] fun, input logic [1:0] sel,
                                    input logic mul_en);
    logic fun_ok;
    fun_ok = 1'b0;
    case (fun)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SUB, ALU_SLT, ALU_SLTU, ALU_LUI: fun_ok = 1'b1;
      ALU_MUL:                             fun_ok = mul_en;
      default:                             fun_ok = 1'b0;
    endcase
    return fun_ok && (sel != 2'd3);
  endfunction

endpackage

// File: rtl/exec_alu_lane.sv
// One execute lane: B-operand mux, ALU and result flags (purely combinational).
// Op C (MUL) is legal only when EXEC_MUL_EN is defined.
module exec_alu_lane
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             lane_en,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] sign_ext_imm,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       src_b_sel,
  input  logic [3:0]       alu_fun,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             is_mul
);

`ifdef EXEC_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] raw_s;
  logic [SHW-1:0]   shift_s;
  logic             raw_ovf_s;
  logic             legal_s;

  // Operand select and raw ALU result
  always_comb begin
    b_s = '0;
    case (src_b_sel)
      SRC_REG:   b_s = data_b;
      SRC_IMM:   b_s = sign_ext_imm;
      SRC_SHAMT: b_s = {{(WIDTH-SHW){1'b0}}, shamt};
      default:   b_s = '0;
    endcase
    shift_s   = b_s[SHW-1:0];
    sum_s     = data_a + b_s;
    diff_s    = data_a - b_s;
    raw_s     = '0;
    raw_ovf_s = 1'b0;
    case (alu_fun)
      ALU_AND:  raw_s = data_a & b_s;
      ALU_OR:   raw_s = data_a | b_s;
      ALU_ADD: begin
        raw_s     = sum_s;
        raw_ovf_s = (data_a[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != data_a[WIDTH-1]);
      end
      ALU_XOR:  raw_s = data_a ^ b_s;
      ALU_NOR:  raw_s = ~(data_a | b_s);
      ALU_SLL:  raw_s = data_a << shift_s;
      ALU_SRL:  raw_s = data_a >> shift_s;
      ALU_SRA:  raw_s = $unsigned($signed(data_a) >>> shift_s);
      ALU_SUB: begin
        raw_s     = diff_s;
        raw_ovf_s = (data_a[WIDTH-1] != b_s[WIDTH-1]) && (diff_s[WIDTH-1] != data_a[WIDTH-1]);
      end
      ALU_SLT:  raw_s = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(b_s))};
      ALU_SLTU: raw_s = {{(WIDTH-1){1'b0}}, (data_a < b_s)};
      ALU_LUI:  raw_s = b_s << 5'd16;
      ALU_MUL:  raw_s = data_a * b_s;
      default:  raw_s = '0;
    endcase
  end

  // Lane masking: disabled lanes are silent, illegal lanes only raise illegal
  always_comb begin
    legal_s = op_legal(alu_fun, src_b_sel, MUL_EN);
    result  = '0;
    zero    = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    is_mul  = 1'b0;
    if (!lane_en) begin
      result = '0;
    end else if (!legal_s) begin
      illegal = 1'b1;
    end else begin
      result = raw_s;
      zero   = (raw_s == '0);
      ovf    = raw_ovf_s;
      is_mul = (alu_fun == ALU_MUL);
    end
  end

endmodule

// File: rtl/exec_stage_nlane.sv
// N-lane execute stage: per-lane ALUs, registered result bundle with valid/ready
// handshake and flush. EXEC_MUL_EN adds the multi-cycle MUL hold counter.
module exec_stage_nlane
  import exec_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES*WIDTH-1:0] data_a,
  input  logic [LANES*WIDTH-1:0] data_b,
  input  logic [LANES*WIDTH-1:0] sign_ext_imm,
  input  logic [LANES*SHW-1:0]   shamt,
  input  logic [LANES*2-1:0]     src_b_sel,
  input  logic [LANES*4-1:0]     alu_fun,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_en,
  output logic [LANES*WIDTH-1:0] alu_result,
  output logic [LANES-1:0]       zero,
  output logic [LANES-1:0]       ovf,
  output logic [LANES-1:0]       illegal
);

  if (LANES < 1 || LANES > 4 || MUL_LAT < 1) begin : g_bad_param
    $error("exec_stage_nlane: LANES must be 1..4 and MUL_LAT >= 1");
  end

  logic [WIDTH-1:0]       res_arr_s  [LANES];
  logic                   zero_arr_s [LANES];
  logic                   ovf_arr_s  [LANES];
  logic                   ill_arr_s  [LANES];
  logic                   mul_arr_s  [LANES];

  logic [LANES*WIDTH-1:0] lane_result_s;
  logic [LANES-1:0]       lane_zero_s;
  logic [LANES-1:0]       lane_ovf_s;
  logic [LANES-1:0]       lane_ill_s;
  logic                   any_mul_s;
  logic                   busy_s;
  logic                   mul_done_s;
  logic                   in_ready_s;
  logic                   accept_s;

  logic                   out_valid_r;
  logic [LANES-1:0]       out_lane_en_r;
  logic [LANES*WIDTH-1:0] result_r;
  logic [LANES-1:0]       zero_r;
  logic [LANES-1:0]       ovf_r;
  logic [LANES-1:0]       illegal_r;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exec_alu_lane #(.WIDTH(WIDTH), .SHW(SHW)) u_lane (
      .lane_en      (lane_en[g]),
      .data_a       (data_a[g*WIDTH +: WIDTH]),
      .data_b       (data_b[g*WIDTH +: WIDTH]),
      .sign_ext_imm (sign_ext_imm[g*WIDTH +: WIDTH]),
      .shamt        (shamt[g*SHW +: SHW]),
      .src_b_sel    (src_b_sel[g*2 +: 2]),
      .alu_fun      (alu_fun[g*4 +: 4]),
      .result       (res_arr_s[g]),
      .zero         (zero_arr_s[g]),
      .ovf          (ovf_arr_s[g]),
      .illegal      (ill_arr_s[g]),
      .is_mul       (mul_arr_s[g])
    );
  end

  // Pack per-lane results into bundle vectors
  always_comb begin
    lane_result_s = '0;
    lane_zero_s   = '0;
    lane_ovf_s    = '0;
    lane_ill_s    = '0;
    any_mul_s     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_result_s[i*WIDTH +: WIDTH] = res_arr_s[i];
      lane_zero_s[i] = zero_arr_s[i];
      lane_ovf_s[i]  = ovf_arr_s[i];
      lane_ill_s[i]  = ill_arr_s[i];
      any_mul_s      = any_mul_s | mul_arr_s[i];
    end
  end

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(MUL_LAT + 1);
  logic [CNT_W-1:0] mul_cnt_r;

  assign busy_s     = (mul_cnt_r != '0);
  assign mul_done_s = (mul_cnt_r == CNT_W'(1));

  // MUL hold counter: loaded on a MUL bundle, result released as it hits zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_cnt_r <= '0;
    end else if (flush) begin
      mul_cnt_r <= '0;
    end else if (accept_s && any_mul_s) begin
      mul_cnt_r <= CNT_W'(MUL_LAT);
    end else if (busy_s) begin
      mul_cnt_r <= mul_cnt_r - CNT_W'(1);
    end else begin
      mul_cnt_r <= mul_cnt_r;
    end
  end
`else
  assign busy_s     = 1'b0;
  assign mul_done_s = 1'b0;
`endif

  assign in_ready_s = !busy_s && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s && !flush;

  // Output bundle register; a MUL bundle stays invisible until the counter expires
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_lane_en_r <= '0;
      result_r      <= '0;
      zero_r        <= '0;
      ovf_r         <= '0;
      illegal_r     <= '0;
    end else if (flush) begin
      out_valid_r   <= 1'b0;
    end else if (accept_s) begin
      out_valid_r   <= !any_mul_s;
      out_lane_en_r <= lane_en;
      result_r      <= lane_result_s;
      zero_r        <= lane_zero_s;
      ovf_r         <= lane_ovf_s;
      illegal_r     <= lane_ill_s;
    end else if (mul_done_s) begin
      out_valid_r   <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_lane_en = out_lane_en_r;
  assign alu_result  = result_r;
  assign zero        = zero_r;
  assign ovf         = ovf_r;
  assign illegal     = illegal_r;

endmodule

// File: tb/tb_exec_stage_nlane.sv
// Directed, table-driven bench for exec_stage_nlane (LANES=2, WIDTH=32);
// the MUL sequences are exercised only when EXEC_MUL_EN is defined.
module tb_exec_stage_nlane;

  localparam int LANES   = 2;
  localparam int WIDTH   = 32;
  localparam int SHW     = 5;
  localparam int MUL_LAT = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES-1:0]       lane_en;
  logic [LANES*WIDTH-1:0] data_a;
  logic [LANES*WIDTH-1:0] data_b;
  logic [LANES*WIDTH-1:0] sign_ext_imm;
  logic [LANES*SHW-1:0]   shamt;
  logic [LANES*2-1:0]     src_b_sel;
  logic [LANES*4-1:0]     alu_fun;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_lane_en;
  logic [LANES*WIDTH-1:0] alu_result;
  logic [LANES-1:0]       zero;
  logic [LANES-1:0]       ovf;
  logic [LANES-1:0]       illegal;

  int checks = 0;
  int errors = 0;

  exec_stage_nlane #(.LANES(LANES), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .lane_en(lane_en), .data_a(data_a), .data_b(data_b), .sign_ext_imm(sign_ext_imm),
    .shamt(shamt), .src_b_sel(src_b_sel), .alu_fun(alu_fun), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane_en(out_lane_en), .alu_result(alu_result),
    .zero(zero), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Fields are {lane1, lane0}
  typedef struct {
    logic [1:0]  en;
    logic [7:0]  fun;
    logic [3:0]  sel;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [9:0]  sh;
    logic [63:0] res;
    logic [1:0]  z;
    logic [1:0]  o;
    logic [1:0]  il;
  } vec_t;

  vec_t vecs[16];
  int   n_vec = 0;
  vec_t mulv;

  task automatic add(input vec_t v);
    vecs[n_vec] = v;
    n_vec++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    lane_en      = v.en;
    alu_fun      = v.fun;
    src_b_sel    = v.sel;
    data_a       = v.a;
    data_b       = v.b;
    sign_ext_imm = v.imm;
    shamt        = v.sh;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, ".valid"},   {63'd0, out_valid}, 64'd1);
    check({tag, ".lane_en"}, {62'd0, out_lane_en}, {62'd0, v.en});
    check({tag, ".result"},  alu_result, v.res);
    check({tag, ".zero"},    {62'd0, zero}, {62'd0, v.z});
    check({tag, ".ovf"},     {62'd0, ovf}, {62'd0, v.o});
    check({tag, ".illegal"}, {62'd0, illegal}, {62'd0, v.il});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // en, fun, sel, a, b, imm, sh, res, z, o, il
    add('{2'b11, {4'h8, 4'h2}, {2'd1, 2'd0}, {32'd3, 32'd7}, {32'd0, 32'd5}, {32'd3, 32'd0},
          {5'd0, 5'd0}, {32'd0, 32'd12}, 2'b10, 2'b00, 2'b00});
    add('{2'b11, {4'h7, 4'h2}, {2'd2, 2'd0}, {32'h80000000, 32'h7FFFFFFF}, {32'd0, 32'd1},
          64'd0, {5'd4, 5'd0}, {32'hF8000000, 32'h80000000}, 2'b00, 2'b01, 2'b00});
    add('{2'b11, {4'hE, 4'h2}, {2'd0, 2'd3}, {32'd5, 32'd5}, {32'd5, 32'd5}, 64'd0,
          10'd0, 64'd0, 2'b00, 2'b00, 2'b11});
    add('{2'b01, {4'h2, 4'h3}, {2'd0, 2'd0}, {32'd1, 32'hFF00FF00}, {32'd1, 32'h0F0F0F0F},
          64'd0, 10'd0, {32'd0, 32'hF00FF00F}, 2'b00, 2'b00, 2'b00});
    add('{2'b11, {4'hA, 4'h9}, {2'd0, 2'd0}, {32'hFFFFFFFF, 32'hFFFFFFFF}, {32'd1, 32'd1},
          64'd0, 10'd0, {32'd0, 32'd1}, 2'b10, 2'b00, 2'b00});
    add('{2'b11, {4'hB, 4'h8}, {2'd0, 2'd0}, {32'd0, 32'h80000000}, {32'h1234, 32'd1},
          64'd0, 10'd0, {32'h12340000, 32'h7FFFFFFF}, 2'b00, 2'b01, 2'b00});
    add('{2'b11, {4'h5, 4'h4}, {2'd1, 2'd0}, {32'd1, 32'd0}, {32'd0, 32'd0}, {32'h23, 32'd0},
          10'd0, {32'd8, 32'hFFFFFFFF}, 2'b00, 2'b00, 2'b00});
    add('{2'b11, {4'h0, 4'h6}, {2'd0, 2'd2}, {32'hF0, 32'h80000000}, {32'h0F, 32'd0}, 64'd0,
          {5'd0, 5'd31}, {32'd0, 32'd1}, 2'b10, 2'b00, 2'b00});
    add('{2'b11, {4'hF, 4'hD}, {2'd0, 2'd0}, {32'd9, 32'd9}, {32'd9, 32'd9}, 64'd0,
          10'd0, 64'd0, 2'b00, 2'b00, 2'b11});
    add('{2'b00, {4'h2, 4'h2}, {2'd0, 2'd0}, {32'd1, 32'd0}, {32'd0, 32'd0}, 64'd0,
          10'd0, 64'd0, 2'b00, 2'b00, 2'b00});
    add('{2'b11, {4'h2, 4'h2}, {2'd0, 2'd0}, {32'd1, 32'h80000000}, {32'hFFFFFFFF, 32'h80000000},
          64'd0, 10'd0, 64'd0, 2'b11, 2'b01, 2'b00});
`ifndef EXEC_MUL_EN
    add('{2'b11, {4'hC, 4'h1}, {2'd0, 2'd0}, {32'd6, 32'd0}, {32'd7, 32'd0}, 64'd0,
          10'd0, 64'd0, 2'b01, 2'b00, 2'b10});
`endif
    mulv = '{2'b01, {4'h0, 4'hC}, {2'd0, 2'd0}, {32'd0, 32'd6}, {32'd0, 32'd7}, 64'd0,
             10'd0, {32'd0, 32'd42}, 2'b00, 2'b00, 2'b00};

    // Reset held two cycles with in_valid asserted
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid",   {63'd0, out_valid}, 64'd0);
    check("rst.lane_en", {62'd0, out_lane_en}, 64'd0);
    check("rst.result",  alu_result, 64'd0);
    check("rst.flags",   {58'd0, zero, ovf, illegal}, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", {63'd0, in_ready}, 64'd1);

    // Table vectors back to back, each drained while the next is captured
    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_out($sformatf("vec%0d", i), vecs[i]);
    end
    @(posedge clk);
    #1;
    check("drain.valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: held output, then accept+drain in the same cycle
    drive(vecs[0]);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_out("stall.first", vecs[0]);
    drive(vecs[1]);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d.in_ready", k), {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("stall%0d.result", k), alu_result, vecs[0].res);
      check($sformatf("stall%0d.valid", k), {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("stall.release.in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("stall.next", vecs[1]);

    // Flush beats a simultaneous capture
    drive(vecs[2]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("flush.pre.valid", {63'd0, out_valid}, 64'd1);
    drive(vecs[3]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush.valid", {63'd0, out_valid}, 64'd0);
    check("flush.in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("flush.after.valid", {63'd0, out_valid}, 64'd0);

`ifdef EXEC_MUL_EN
    // MUL holds the stage MUL_LAT cycles, result appears on cycle MUL_LAT+1
    drive(mulv);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      check($sformatf("mul.c%0d.in_ready", k), {63'd0, in_ready}, 64'd0);
      check($sformatf("mul.c%0d.valid", k), {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    check_out("mul.result", mulv);
    @(posedge clk);
    #1;
    check("mul.drain.valid", {63'd0, out_valid}, 64'd0);

    // Flush in the second busy cycle aborts the multiply
    drive(mulv);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mulflush.c1.in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("mulflush.in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < MUL_LAT + 1; k++) begin
      check($sformatf("mulflush.valid%0d", k), {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
